serial_byte_collector: RTL

- Downstream consumer of the 1-bit counter-LSB stream produced by the counter stage.
- Deserializes qualified bits into WIDTH-bit words and buffers them in a 2-entry output FIFO with a valid/ready handshake.
- Checks the stream against the expected alternating 0/1 pattern (an incrementing counter's LSB toggles every cycle) and counts violations.

---
 rtl/serial_byte_collector.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_byte_collector.sv
// rtl/serial_byte_collector.sv - deserializer, 2-entry output FIFO and alternating-pattern checker
//
// Collects qualified serial bits into WIDTH-bit words, queues them in a
// 2-entry FIFO with a valid/ready handshake, and counts cycles where the
// received bit fails to toggle relative to the previous received bit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_bit     serial data bit
//   in_valid   qualifies in_bit this cycle
//   clr_stats  synchronous clear of overflow, err_cnt, drop_cnt
//   out_data   head-of-FIFO word
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts out_data when out_valid & out_ready
//   overflow   sticky: a completed word was dropped
//   err_cnt    saturating count of pattern violations
//   drop_cnt   saturating count of dropped words
//   locked     checker holds a reference bit
module serial_byte_collector #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_stats,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             locked
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, TRACK} state_t;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pos;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  state_t state;
  state_t state_next;
  logic   last_bit;
  logic   err_hit;

  // Assembled word including the bit arriving this cycle, so a completing
  // word can be pushed on the same edge as its last bit.
  always_comb begin
    pos = (LSB_FIRST != 0) ? idx : (IDX_LAST - idx);
    word_next = shreg;
    word_next[pos] = in_bit;
  end

  assign push_req = in_valid && (idx == IDX_LAST);
  assign pop      = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && ((count != 2'd2) || pop);
  assign drop     = push_req && (count == 2'd2) && !pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      shreg  <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        shreg <= word_next;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr] <= word_next;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  always_comb begin
    state_next = state;
    err_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (in_valid && (in_bit == last_bit)) begin
          err_hit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_bit <= 1'b0;
    end else begin
      state <= state_next;
      if (in_valid) begin
        last_bit <= in_bit;
      end
    end
  end

  assign locked = (state == TRACK);

  // Clear takes priority; an increment on the same edge is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clr_stats) begin
      overflow <= 1'b0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (err_hit && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != CNT_MAX) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
